// File: rtl/nn_classifier_feeder_if.sv
// Handshake and data bundle between the classifier feeder and its neighbours:
// latent input stream, weight/bias write port, classifier drive/return lines,
// result output stream and busy status.
// slave  : the feeder itself.
// master : the environment (encoder, host writer, classifier, consumer).
interface nn_classifier_feeder_if #(
  parameter int DW = 16
);
  logic          z_valid;
  logic [DW-1:0] z_data;
  logic          z_ready;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic          cls_en;
  logic [DW-1:0] cls_atas;
  logic [DW-1:0] cls_kiri;
  logic [DW-1:0] cls_bias;
  logic [DW-1:0] cls_res;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_class;
  logic          res_ready;
  logic          busy;

  modport slave (
    input  z_valid, z_data, wr_en, wr_addr, wr_data, cls_res, res_ready,
    output z_ready, wr_err, cls_en, cls_atas, cls_kiri, cls_bias,
           res_valid, res_data, res_class, busy
  );

  modport master (
    output z_valid, z_data, wr_en, wr_addr, wr_data, cls_res, res_ready,
    input  z_ready, wr_err, cls_en, cls_atas, cls_kiri, cls_bias,
           res_valid, res_data, res_class, busy
  );
endinterface

// File: rtl/nn_classifier_feeder.sv
// nn_classifier_feeder: buffers one latent vector, streams it together with
// stored weights and bias into the systolic classifier for one fixed-length
// run, captures the classifier result and hands logit + class bit downstream.
// Optional feature macro: NN_CLS_FEEDER_THRESH_EN adds a programmable signed
// threshold at write address N_IN+1 used for the class decision; without it
// the class bit is simply "logit >= 0".
module nn_classifier_feeder #(
  parameter int N_IN    = 9,
  parameter int RUN_LEN = 13,
  parameter int DW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nn_classifier_feeder_if.slave bus
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  // Run counter must be able to hold RUN_LEN for the cycle it leaves RUN.
  localparam int RUN_W = $clog2(RUN_LEN + 1);
`ifdef NN_CLS_FEEDER_THRESH_EN
  localparam int ADDR_MAX = N_IN + 1;
`else
  localparam int ADDR_MAX = N_IN;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_IN - 1);
  localparam logic [RUN_W-1:0] LAST_RUN   = RUN_W'(RUN_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_ELEMS  = RUN_W'(N_IN);
  localparam logic [3:0]       ADDR_MAX_A = 4'(ADDR_MAX);
  localparam logic [3:0]       BIAS_ADDR  = 4'(N_IN);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_CAPT = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [IDX_W-1:0] idx_r;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_next_s;

  logic [DW-1:0]    zbuf_r [N_IN];
  logic [DW-1:0]    w_r    [N_IN];
  logic [DW-1:0]    bias_r;
`ifdef NN_CLS_FEEDER_THRESH_EN
  logic [DW-1:0]    thresh_r;
`endif

  logic             z_ready_r;
  logic             wr_err_r;
  logic             busy_r;
  logic             cls_en_r;
  logic [DW-1:0]    cls_atas_r;
  logic [DW-1:0]    cls_kiri_r;
  logic [DW-1:0]    cls_bias_r;
  logic             res_valid_r;
  logic [DW-1:0]    res_data_r;
  logic             res_class_r;

  logic             z_hs_s;
  logic             res_hs_s;
  logic             wr_allowed_s;
  logic             wr_ok_s;
  logic             wr_bad_s;
  logic             el_live_s;
  logic [IDX_W-1:0] el_idx_s;
  logic [DW-1:0]    atas_next_s;
  logic [DW-1:0]    kiri_next_s;
  logic [DW-1:0]    bias_next_s;
  logic             class_s;

  // Handshake qualification and write-port acceptance.
  always_comb begin
    z_hs_s       = bus.z_valid && z_ready_r;
    res_hs_s     = res_valid_r && bus.res_ready;
    wr_allowed_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_LOAD, ST_OUT: wr_allowed_s = 1'b1;
      default:                  wr_allowed_s = 1'b0;
    endcase
    wr_ok_s  = bus.wr_en && wr_allowed_s && (bus.wr_addr <= ADDR_MAX_A);
    wr_bad_s = bus.wr_en && !wr_ok_s;
  end

  // Next-state logic and run-counter advance.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.z_valid) state_next_s = ST_LOAD;
        else             state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (z_hs_s && (idx_r == LAST_IDX)) state_next_s = ST_RUN;
        else                               state_next_s = ST_LOAD;
      end
      ST_RUN: begin
        if (run_r == LAST_RUN) state_next_s = ST_CAPT;
        else                   state_next_s = ST_RUN;
      end
      ST_CAPT: state_next_s = ST_OUT;
      ST_OUT: begin
        if (res_hs_s) state_next_s = ST_IDLE;
        else          state_next_s = ST_OUT;
      end
      default: state_next_s = ST_IDLE;
    endcase
    if (state_r == ST_RUN) run_next_s = run_r + RUN_W'(1);
    else                   run_next_s = '0;
  end

  // Values the classifier lines take next cycle; a write landing on the same
  // edge that enters RUN is forwarded so it is seen by that run.
  always_comb begin
    el_live_s   = (state_next_s == ST_RUN) && (run_next_s < RUN_ELEMS);
    el_idx_s    = IDX_W'(run_next_s);
    atas_next_s = '0;
    kiri_next_s = '0;
    bias_next_s = '0;
    if (el_live_s) begin
      atas_next_s = zbuf_r[el_idx_s];
      if (wr_ok_s && (bus.wr_addr == 4'(el_idx_s))) kiri_next_s = bus.wr_data;
      else                                         kiri_next_s = w_r[el_idx_s];
    end else begin
      atas_next_s = '0;
      kiri_next_s = '0;
    end
    if (state_next_s == ST_RUN) begin
      if (wr_ok_s && (bus.wr_addr == BIAS_ADDR)) bias_next_s = bus.wr_data;
      else                                      bias_next_s = bias_r;
    end else begin
      bias_next_s = '0;
    end
  end

  // Class decision on the classifier result being captured.
  always_comb begin
`ifdef NN_CLS_FEEDER_THRESH_EN
    class_s = ($signed(bus.cls_res) >= $signed(thresh_r));
`else
    class_s = ~bus.cls_res[DW-1];
`endif
  end

  // State register, latent write index and run counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      run_r   <= '0;
    end else begin
      state_r <= state_next_s;
      run_r   <= run_next_s;
      if (z_hs_s) idx_r <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
      else        idx_r <= idx_r;
    end
  end

  // Latent element buffer, filled in arrival order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) zbuf_r[k] <= '0;
    end else if (z_hs_s) begin
      zbuf_r[idx_r] <= bus.z_data;
    end else begin
      zbuf_r <= zbuf_r;
    end
  end

  // Weight, bias (and threshold) storage written through the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) w_r[k] <= '0;
      bias_r <= '0;
`ifdef NN_CLS_FEEDER_THRESH_EN
      thresh_r <= '0;
`endif
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (wr_ok_s && (bus.wr_addr == 4'(k))) w_r[k] <= bus.wr_data;
      end
      if (wr_ok_s && (bus.wr_addr == BIAS_ADDR)) bias_r <= bus.wr_data;
`ifdef NN_CLS_FEEDER_THRESH_EN
      if (wr_ok_s && (bus.wr_addr == 4'(N_IN + 1))) thresh_r <= bus.wr_data;
`endif
    end
  end

  // Registered classifier drive: live only while in RUN, zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_en_r   <= 1'b0;
      cls_atas_r <= '0;
      cls_kiri_r <= '0;
      cls_bias_r <= '0;
    end else begin
      cls_en_r   <= (state_next_s == ST_RUN);
      cls_atas_r <= atas_next_s;
      cls_kiri_r <= kiri_next_s;
      cls_bias_r <= bias_next_s;
    end
  end

  // Result capture in CAPT; held stable through OUT until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_class_r <= 1'b0;
    end else begin
      res_valid_r <= (state_next_s == ST_OUT);
      if (state_r == ST_CAPT) begin
        res_data_r  <= bus.cls_res;
        res_class_r <= class_s;
      end else begin
        res_data_r  <= res_data_r;
        res_class_r <= res_class_r;
      end
    end
  end

  // Status outputs: input-ready, busy and one-cycle write-reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      wr_err_r  <= 1'b0;
    end else begin
      z_ready_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_LOAD);
      busy_r    <= (state_next_s != ST_IDLE);
      wr_err_r  <= wr_bad_s;
    end
  end

  assign bus.z_ready   = z_ready_r;
  assign bus.wr_err    = wr_err_r;
  assign bus.busy      = busy_r;
  assign bus.cls_en    = cls_en_r;
  assign bus.cls_atas  = cls_atas_r;
  assign bus.cls_kiri  = cls_kiri_r;
  assign bus.cls_bias  = cls_bias_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_class = res_class_r;

endmodule

// File: tb/tb_nn_classifier_feeder.sv
// Self-checking bench for nn_classifier_feeder: directed scenarios plus
// randomized vectors, checked against a simple array-based model of the
// weight/bias store and the expected stream/result of each run.
module tb_nn_classifier_feeder;
  localparam int N_IN    = 9;
  localparam int RUN_LEN = 13;
  localparam int DW      = 16;
`ifdef NN_CLS_FEEDER_THRESH_EN
  localparam int ADDR_MAX = N_IN + 1;
`else
  localparam int ADDR_MAX = N_IN;
`endif

  logic clk = 1'b0;
  logic rst;

  nn_classifier_feeder_if #(.DW(DW)) bus ();

  nn_classifier_feeder #(.N_IN(N_IN), .RUN_LEN(RUN_LEN), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_w [N_IN];
  logic [DW-1:0] m_bias;
  logic [DW-1:0] m_thresh;
  logic [DW-1:0] zvec [N_IN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_class(input logic [DW-1:0] v);
`ifdef NN_CLS_FEEDER_THRESH_EN
    return ($signed(v) >= $signed(m_thresh));
`else
    return ($signed(v) >= 0);
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_IN; k++) m_w[k] = '0;
    m_bias   = '0;
    m_thresh = '0;
  endtask

  // Write while the feeder is idle; rejection depends only on the address.
  task automatic write_reg(input int addr, input logic [DW-1:0] data);
    logic exp_err;
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
    exp_err = (addr > ADDR_MAX);
    chk("wr_err_idle", 32'(bus.wr_err), 32'(exp_err));
    if (!exp_err) begin
      if (addr < N_IN)       m_w[addr] = data;
      else if (addr == N_IN) m_bias    = data;
      else                   m_thresh  = data;
    end
  endtask

  // Offer zvec element by element with random gaps; returns on the negedge
  // after the last handshake.
  task automatic send_vec(input int gap_max);
    int guard;
    for (int k = 0; k < N_IN; k++) begin
      bus.z_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      bus.z_valid = 1'b1;
      bus.z_data  = zvec[k];
      guard = 0;
      while (!bus.z_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      chk("z_handshake_bound", 32'(guard < 20), 32'd1);
      @(negedge clk);
    end
    bus.z_valid = 1'b0;
  endtask

  // One complete transaction: load, check the stream, check capture and
  // result hold under backpressure, then release.
  task automatic run_and_check(input logic [DW-1:0] stub, input int gap_max,
                               input int hold, input bit bad_wr, input int bad_addr);
    int cnt;
    int guard;
    bit pend;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_k;
    logic [DW-1:0] other;
    bus.cls_res = ~stub;
    send_vec(gap_max);
    cnt = 0; guard = 0; pend = 1'b0;
    while (guard < 40) begin
      if (!bus.cls_en) break;
      if (cnt < N_IN) begin
        exp_a = zvec[cnt];
        exp_k = m_w[cnt];
      end else begin
        exp_a = '0;
        exp_k = '0;
      end
      chk("cls_atas", 32'(bus.cls_atas), 32'(exp_a));
      chk("cls_kiri", 32'(bus.cls_kiri), 32'(exp_k));
      chk("cls_bias", 32'(bus.cls_bias), 32'(m_bias));
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("z_ready_run", 32'(bus.z_ready), 32'd0);
      cnt++;
      if (pend) begin
        chk("wr_err_run", 32'(bus.wr_err), 32'd1);
        bus.wr_en = 1'b0;
        pend = 1'b0;
      end
      if (bad_wr && cnt == 4) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(bad_addr);
        bus.wr_data = ~m_w[bad_addr];
        pend = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    bus.wr_en = 1'b0;
    chk("run_len", 32'(cnt), 32'(RUN_LEN));
    chk("capt_res_valid", 32'(bus.res_valid), 32'd0);
    chk("capt_busy", 32'(bus.busy), 32'd1);
    bus.cls_res = stub;
    @(negedge clk);
    other = 16'(~stub + 16'h0001);
    bus.cls_res = other;
    chk("out_res_valid", 32'(bus.res_valid), 32'd1);
    chk("out_res_data", 32'(bus.res_data), 32'(stub));
    chk("out_res_class", 32'(bus.res_class), 32'(model_class(stub)));
    bus.res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_res_data", 32'(bus.res_data), 32'(stub));
      chk("hold_z_ready", 32'(bus.z_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("rel_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rel_z_ready", 32'(bus.z_ready), 32'd1);
    chk("rel_busy", 32'(bus.busy), 32'd0);
  endtask

  // Reset asserted two cycles in the middle of a run.
  task automatic mid_run_reset();
    for (int k = 0; k < N_IN; k++) zvec[k] = 16'($urandom);
    bus.cls_res = 16'h0001;
    send_vec(0);
    repeat (3) @(negedge clk);
    chk("midrun_cls_en", 32'(bus.cls_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cls_en", 32'(bus.cls_en), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_z_ready", 32'(bus.z_ready), 32'd0);
    chk("rst_cls_atas", 32'(bus.cls_atas), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_cls_en", 32'(bus.cls_en), 32'd0);
    chk("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_z_ready", 32'(bus.z_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("no_partial_result", 32'(bus.res_valid | bus.cls_en), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.z_valid   = 1'b0;
    bus.z_data    = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.cls_res   = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    model_reset();

    // Power-on reset state.
    @(negedge clk);
    @(negedge clk);
    chk("por_cls_en", 32'(bus.cls_en), 32'd0);
    chk("por_res_valid", 32'(bus.res_valid), 32'd0);
    chk("por_busy", 32'(bus.busy), 32'd0);
    chk("por_wr_err", 32'(bus.wr_err), 32'd0);
    chk("por_res_data", 32'(bus.res_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_z_ready", 32'(bus.z_ready), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Directed stream: w[k]=k+1, bias=0x0010, z=0x0100+k.
    for (int k = 0; k < N_IN; k++) write_reg(k, 16'(k + 1));
    write_reg(N_IN, 16'h0010);
    for (int k = 0; k < N_IN; k++) zvec[k] = 16'(16'h0100 + k);
    run_and_check(16'hFF00, 0, 0, 1'b0, 0);
    run_and_check(16'h0001, 2, 5, 1'b1, 3);
    run_and_check(16'h8000, 1, 0, 1'b0, 0);
    run_and_check(16'h7FFF, 0, 1, 1'b0, 0);
    run_and_check(16'h0000, 0, 0, 1'b0, 0);

    // Address protection in IDLE.
    write_reg(12, 16'h1234);
    write_reg(15, 16'h5678);
    write_reg(N_IN + 1, 16'h0080);

`ifdef NN_CLS_FEEDER_THRESH_EN
    run_and_check(16'h0070, 0, 0, 1'b0, 0);
    run_and_check(16'h0080, 0, 0, 1'b0, 0);
    run_and_check(16'h007F, 0, 2, 1'b0, 0);
    run_and_check(16'hFFFF, 0, 0, 1'b0, 0);
`endif

    mid_run_reset();
    run_and_check(16'h0042, 0, 0, 1'b0, 0);

    // Randomized transactions.
    for (int t = 0; t < 10; t++) begin
      for (int j = 0; j < 4; j++) write_reg($urandom_range(0, 15), 16'($urandom));
      for (int k = 0; k < N_IN; k++) zvec[k] = 16'($urandom);
      run_and_check(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), $urandom_range(0, N_IN - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
